// File: rtl/ibex_multdiv_param.sv
// ibex_multdiv_param
//   Sequential multiply/divide unit for RV32M/RV64M-style operations.
//   Multiplication runs a WIDTH x MUL_KW kernel over B, one chunk per cycle,
//   LSB chunk first, into a right-shifting accumulator. Division is a
//   restoring divider that retires DIV_BITS quotient bits per cycle on
//   operand magnitudes, with the signs fixed up in a final cycle.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   req_i          operation request, sampled only while busy_o=0
//   op_i           0=MULL 1=MULH 2=DIV 3=REM
//   signed_mode_i  bit0: A signed, bit1: B signed
//   op_a_i         operand A (multiplicand / dividend)
//   op_b_i         operand B (multiplier / divisor)
//   kill_i         abort the current operation (highest priority)
//   busy_o         unit cannot accept a request
//   valid_o        one-cycle pulse, result_o is valid
//   result_o       registered result, held between operations

module ibex_multdiv_param #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_KW   = 16,
   parameter int unsigned DIV_BITS = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [1:0]       op_i,
   input  logic [1:0]       signed_mode_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             kill_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV_ABS,
      ST_DIV_ITER,
      ST_DIV_SIGN,
      ST_DONE
   } state_e;

   localparam int unsigned MUL_N  = WIDTH / MUL_KW;
   localparam int unsigned DIV_N  = WIDTH / DIV_BITS;
   localparam int unsigned ACC_W  = 2 * WIDTH + 1;
   localparam int unsigned PROD_W = WIDTH + MUL_KW + 1;
   localparam int unsigned SUM_W  = 2 * WIDTH + MUL_KW + 1;
   localparam logic [6:0]  MUL_LAST = 7'(MUL_N - 1);
   localparam logic [6:0]  DIV_LAST = 7'(DIV_N - 1);

   state_e             state_q, state_d;
   md_op_e             op_q, op_d;
   logic [1:0]         smode_q, smode_d;
   logic [WIDTH-1:0]   a_q, a_d;        // A, then |dividend| / quotient shift register
   logic [WIDTH-1:0]   b_q, b_d;        // B, then multiplier chunks / |divisor|
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [6:0]         cnt_q, cnt_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic busy;
   logic accept;

   // ------------------------------------------------------------------
   // Multiply kernel: signed (WIDTH+1) x signed (MUL_KW+1). Only the top
   // chunk of B can carry a sign; lower chunks are always unsigned.
   // ------------------------------------------------------------------
   logic [MUL_KW-1:0]        mul_chunk;
   logic                     mul_top;
   logic [MUL_KW:0]          mul_chunk_ext;
   logic [WIDTH:0]           mul_a_ext;
   logic signed [PROD_W-1:0] mul_prod;
   logic [SUM_W-1:0]         mul_sum;
   logic [ACC_W-1:0]         mul_acc_next;

   assign mul_chunk     = b_q[MUL_KW-1:0];
   assign mul_top       = (cnt_q == MUL_LAST);
   assign mul_chunk_ext = {mul_top & smode_q[1] & mul_chunk[MUL_KW-1], mul_chunk};
   assign mul_a_ext     = {smode_q[0] & a_q[WIDTH-1], a_q};
   assign mul_prod      = $signed({{MUL_KW{mul_a_ext[WIDTH]}}, mul_a_ext}) *
                          $signed({{WIDTH{mul_chunk_ext[MUL_KW]}}, mul_chunk_ext});
   // Each partial product enters at weight 2^WIDTH; after MUL_N right shifts
   // of MUL_KW the accumulator holds the full product at bit 0. Low retired
   // bits slide down into the lower half, so nothing is lost.
   assign mul_sum       = {{MUL_KW{acc_q[ACC_W-1]}}, acc_q} + {mul_prod, {WIDTH{1'b0}}};
   assign mul_acc_next  = ACC_W'(mul_sum >> MUL_KW);

   // ------------------------------------------------------------------
   // Divide step: shift DIV_BITS dividend bits into the partial remainder
   // and subtract the largest divisor multiple that fits.
   // ------------------------------------------------------------------
   logic [WIDTH+DIV_BITS-1:0] div_shift;
   logic [WIDTH-1:0]          div_rem_next;
   logic [DIV_BITS-1:0]       div_digit;

   assign div_shift = {rem_q, a_q[WIDTH-1 -: DIV_BITS]};

   generate
      if (DIV_BITS == 1) begin : g_radix2
         logic [WIDTH+1:0] d1;
         assign d1 = {1'b0, div_shift} - {2'b00, b_q};
         always_comb begin
            div_rem_next = WIDTH'(div_shift);
            div_digit    = 1'b0;
            if (!d1[WIDTH+1]) begin
               div_rem_next = WIDTH'(d1);
               div_digit    = 1'b1;
            end
         end
      end else begin : g_radix4
         logic [WIDTH+1:0] m1, m2, m3;
         logic [WIDTH+2:0] d1, d2, d3;
         assign m1 = {2'b00, b_q};
         assign m2 = {1'b0, b_q, 1'b0};
         assign m3 = m1 + m2;
         // Three parallel trial subtractions; the MSB is the borrow.
         assign d1 = {1'b0, div_shift} - {1'b0, m1};
         assign d2 = {1'b0, div_shift} - {1'b0, m2};
         assign d3 = {1'b0, div_shift} - {1'b0, m3};
         always_comb begin
            div_rem_next = WIDTH'(div_shift);
            div_digit    = 2'd0;
            if (!d3[WIDTH+2]) begin
               div_rem_next = WIDTH'(d3);
               div_digit    = 2'd3;
            end else if (!d2[WIDTH+2]) begin
               div_rem_next = WIDTH'(d2);
               div_digit    = 2'd2;
            end else if (!d1[WIDTH+2]) begin
               div_rem_next = WIDTH'(d1);
               div_digit    = 2'd1;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV_ABS) ||
                   (state_q == ST_DIV_ITER) || (state_q == ST_DIV_SIGN);
   assign accept = req_i & ~busy & ~kill_i;

   always_comb begin
      logic s_a, s_b;
      state_d  = state_q;
      op_d     = op_q;
      smode_d  = smode_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      s_a      = smode_q[0] & a_q[WIDTH-1];
      s_b      = smode_q[1] & b_q[WIDTH-1];

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_d    = md_op_e'(op_i);
               smode_d = signed_mode_i;
               a_d     = op_a_i;
               b_d     = op_b_i;
               cnt_d   = '0;
               acc_d   = '0;
               rem_d   = '0;
               if (op_i == MD_OP_MULL || op_i == MD_OP_MULH) begin
                  state_d = ST_MUL;
               end else if (op_b_i == '0) begin
                  // Divide by zero finishes immediately.
                  state_d  = ST_DONE;
                  result_d = (op_i == MD_OP_DIV) ? '1 : op_a_i;
               end else begin
                  state_d = ST_DIV_ABS;
               end
            end
         end

         ST_MUL: begin
            acc_d    = mul_acc_next;
            b_d      = b_q >> MUL_KW;
            cnt_d    = cnt_q + 7'd1;
            result_d = (op_q == MD_OP_MULL) ? mul_acc_next[WIDTH-1:0]
                                            : mul_acc_next[2*WIDTH-1:WIDTH];
            if (cnt_q == MUL_LAST) begin
               state_d = ST_DONE;
            end
         end

         ST_DIV_ABS: begin
            // Negating MIN leaves MIN, which read unsigned is the right magnitude.
            a_d     = s_a ? -a_q : a_q;
            b_d     = s_b ? -b_q : b_q;
            q_neg_d = s_a ^ s_b;
            r_neg_d = s_a;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ST_DIV_ITER;
         end

         ST_DIV_ITER: begin
            rem_d = div_rem_next;
            a_d   = {a_q[WIDTH-1-DIV_BITS:0], div_digit};
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == DIV_LAST) begin
               state_d = ST_DIV_SIGN;
            end
         end

         ST_DIV_SIGN: begin
            if (op_q == MD_OP_DIV) begin
               result_d = q_neg_q ? -a_q : a_q;
            end else begin
               result_d = r_neg_q ? -rem_q : rem_q;
            end
            state_d = ST_DONE;
         end

         default: state_d = ST_IDLE;
      endcase

      // Kill overrides everything, and leaves the visible result untouched.
      if (kill_i) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_OP_MULL;
         smode_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         smode_q  <= smode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = busy;
   assign valid_o  = (state_q == ST_DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_param.sv
// Testbench for ibex_multdiv_param: a radix-4 and a radix-2 instance share
// all inputs; each directed operation is checked on both for result and
// latency. Also covers kill, back-to-back issue and async reset.

module tb_ibex_multdiv_param;

   localparam logic [1:0] OP_MULL = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;
   localparam logic [1:0] OP_REM  = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        kill;
   logic [1:0]  op;
   logic [1:0]  sm;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy4, valid4, busy2, valid2;
   logic [31:0] res4, res2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibex_multdiv_param #(.WIDTH(32), .MUL_KW(16), .DIV_BITS(2)) u_dut_r4 (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .op_i          (op),
      .signed_mode_i (sm),
      .op_a_i        (a),
      .op_b_i        (b),
      .kill_i        (kill),
      .busy_o        (busy4),
      .valid_o       (valid4),
      .result_o      (res4)
   );

   ibex_multdiv_param #(.WIDTH(32), .MUL_KW(16), .DIV_BITS(1)) u_dut_r2 (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .op_i          (op),
      .signed_mode_i (sm),
      .op_a_i        (a),
      .op_b_i        (b),
      .kill_i        (kill),
      .busy_o        (busy2),
      .valid_o       (valid2),
      .result_o      (res2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Call at a falling edge; issues the request in that cycle (cycle 0).
   // Returns at the falling edge of the slower instance's DONE cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] s,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vexp,
                         input int lat4_exp, input int lat2_exp);
      int          cyc;
      int          lat4, lat2;
      logic [31:0] r4, r2;
      logic        busy_c1;
      req = 1'b1; op = o; sm = s; a = va; b = vb;
      cyc = 0; lat4 = 0; lat2 = 0; r4 = '0; r2 = '0; busy_c1 = 1'b0;
      while ((lat4 == 0 || lat2 == 0) && cyc < 200) begin
         @(negedge clk);
         // Scramble inputs after accept; they must not matter.
         req = 1'b0; op = 2'($urandom); sm = 2'($urandom); a = $urandom; b = $urandom;
         cyc++;
         if (cyc == 1) busy_c1 = busy4;
         if (valid4 && lat4 == 0) begin
            lat4 = cyc; r4 = res4;
            check({tag, " busy_at_done_r4"}, busy4, 0);
         end
         if (valid2 && lat2 == 0) begin
            lat2 = cyc; r2 = res2;
            check({tag, " busy_at_done_r2"}, busy2, 0);
         end
      end
      check({tag, " res_r4"}, r4, vexp);
      check({tag, " res_r2"}, r2, vexp);
      check({tag, " lat_r4"}, lat4, lat4_exp);
      check({tag, " lat_r2"}, lat2, lat2_exp);
      check({tag, " busy_c1"}, busy_c1, (lat4_exp > 1));
      $display("op %s a=%h b=%h res_r4=%h res_r2=%h lat=%0d/%0d", tag, va, vb, r4, r2, lat4, lat2);
   endtask

   initial begin
      int stray;
      rst = 1'b1; req = 1'b0; kill = 1'b0; op = '0; sm = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset busy_r4", busy4, 0);
      check("reset valid_r4", valid4, 0);
      check("reset res_r4", res4, 0);
      check("reset busy_r2", busy2, 0);
      check("reset valid_r2", valid2, 0);
      check("reset res_r2", res2, 0);
      rst = 1'b0;
      @(negedge clk);

      // Multiply
      run_op("mull_basic", OP_MULL, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 3);
      run_op("mulh_ss",    OP_MULH, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3, 3);
      run_op("mulh_su",    OP_MULH, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 3);
      run_op("mulh_uu",    OP_MULH, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 3, 3);
      run_op("mulh_us",    OP_MULH, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 3);
      run_op("mull_neg",   OP_MULL, 2'b11, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 3, 3);
      run_op("mulh_umax",  OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 3);
      run_op("mull_umax",  OP_MULL, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 3);

      // Divide (this DIV is issued in the DONE cycle of the MULL above)
      run_op("div_m7_2",   OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 19, 35);
      run_op("rem_m7_2",   OP_REM, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 19, 35);
      run_op("div_b0",     OP_DIV, 2'b11, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1);
      run_op("rem_b0",     OP_REM, 2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1, 1);
      run_op("div_ovf",    OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 19, 35);
      run_op("rem_ovf",    OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 19, 35);
      run_op("divu_100_7", OP_DIV, 2'b00, 32'd100,       32'd7,         32'd14,        19, 35);
      run_op("remu_100_7", OP_REM, 2'b00, 32'd100,       32'd7,         32'd2,         19, 35);
      run_op("divu_max_3", OP_DIV, 2'b00, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 19, 35);
      run_op("div_7_m2",   OP_DIV, 2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 19, 35);
      run_op("rem_7_m2",   OP_REM, 2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 19, 35);
      run_op("remu_bigdv", OP_REM, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 19, 35);
      run_op("divu_max16", OP_DIV, 2'b00, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 19, 35);
      run_op("remu_max16", OP_REM, 2'b00, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 19, 35);

      // Kill during DIV_ITER (cycle 10)
      @(negedge clk);
      req = 1'b1; op = OP_DIV; sm = 2'b00; a = 32'h0000_1000; b = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         req = 1'b0;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy_r4", busy4, 0);
      check("kill busy_r2", busy2, 0);
      check("kill valid_r4", valid4, 0);
      check("kill valid_r2", valid2, 0);
      check("kill res_r4", res4, 32'h0000_000F);
      check("kill res_r2", res2, 32'h0000_000F);
      $display("kill in DIV_ITER cycle 10 res_r4=%h res_r2=%h", res4, res2);
      run_op("mull_after_kill", OP_MULL, 2'b00, 32'h0000_1234, 32'h0001_0010, 32'h1235_2340, 3, 3);
      stray = 0;
      repeat (40) begin
         @(negedge clk);
         stray += int'(valid4) + int'(valid2);
      end
      check("no_valid_after_kill", stray, 0);

      // Kill together with a request in the DONE cycle
      req = 1'b1; op = OP_MULL; sm = 2'b00; a = 32'd3; b = 32'd5;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("kd valid_r4", valid4, 1);
      req = 1'b1; kill = 1'b1; a = 32'd7; b = 32'd7;
      @(negedge clk);
      req = 1'b0; kill = 1'b0;
      check("kd busy_r4", busy4, 0);
      check("kd busy_r2", busy2, 0);
      check("kd valid_r4", valid4, 0);
      check("kd res_r4", res4, 32'd15);
      $display("kill+req in DONE busy=%b valid=%b res=%h", busy4, valid4, res4);

      // Kill together with a request while idle: no accept
      req = 1'b1; kill = 1'b1;
      @(negedge clk);
      req = 1'b0; kill = 1'b0;
      check("ki busy_r4", busy4, 0);
      check("ki busy_r2", busy2, 0);

      // Async reset mid-MUL
      req = 1'b1; op = OP_MULL; sm = 2'b00; a = 32'd2; b = 32'd3;
      @(negedge clk);
      req = 1'b0;
      check("rm busy_before", busy4, 1);
      #1 rst = 1'b1;
      #1;
      check("rm busy_r4", busy4, 0);
      check("rm valid_r4", valid4, 0);
      check("rm res_r4", res4, 0);
      check("rm busy_r2", busy2, 0);
      check("rm res_r2", res2, 0);
      $display("async reset mid-MUL busy=%b valid=%b res=%h", busy4, valid4, res4);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         stray += int'(valid4) + int'(valid2);
      end
      check("rm no_valid", stray, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
